// File: rtl/alu_share_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_share_ctrl
//  Purpose  : Shares one combinational 32-bit ALU between two requesters
//             (req0 = execute stage, req1 = address/branch helper). Accepts
//             one operation at a time, drives the ALU from registered
//             operands, captures result/zero and returns them to the owner.
//  Ports    : clk, rst (async, active-high)
//             reqN_valid/ready/a/b/op   - request handshake, N = 0,1
//             rspN_valid/ready/result/zero - response handshake, N = 0,1
//             alu_a/alu_b/alu_control   - to the ALU (registered)
//             alu_result/alu_zero       - from the ALU
//             busy                      - high whenever not idle
//  Params   : PRIORITY_MODE 0 = round-robin, 1 = req0 fixed priority
//  Revision : 1.0 - initial release
// ============================================================================
module alu_share_ctrl #(
    parameter int PRIORITY_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_owner;       // 0 = req0 owns the in-flight op, 1 = req1
    logic        r_last_grant;  // requester granted at the last acceptance
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_op;
    logic [31:0] r_result;
    logic        r_zero;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_rsp_take;

    // Next-state and grant logic. Grants exist only in IDLE, so the two
    // ready outputs can never be high together and never outside IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_rsp_take  = r_owner ? rsp1_ready : rsp0_ready;
        case (r_state)
            ST_IDLE: begin
                // req0 wins when alone, in fixed-priority mode, or when
                // req1 was the last one served.
                w_grant0 = req0_valid &&
                           ((PRIORITY_MODE != 0) || !req1_valid || r_last_grant);
                w_grant1 = req1_valid && !w_grant0;
                if (w_grant0 || w_grant1) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_rsp_take) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand registers load only at acceptance, so the ALU inputs move only
    // on acceptance edges. Response registers load only on EXEC->RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;   // makes req0 win the first contest
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_op         <= 4'd0;
            r_result     <= 32'd0;
            r_zero       <= 1'b0;
        end else begin
            if (w_grant0 || w_grant1) begin
                r_a          <= w_grant1 ? req1_a  : req0_a;
                r_b          <= w_grant1 ? req1_b  : req0_b;
                r_op         <= w_grant1 ? req1_op : req0_op;
                r_owner      <= w_grant1;
                r_last_grant <= w_grant1;
            end
            if (r_state == ST_EXEC) begin
                r_result <= alu_result;
                r_zero   <= alu_zero;
            end
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;

    assign rsp0_valid  = (r_state == ST_RESP) && !r_owner;
    assign rsp1_valid  = (r_state == ST_RESP) &&  r_owner;
    assign rsp0_result = r_result;
    assign rsp1_result = r_result;
    assign rsp0_zero   = r_zero;
    assign rsp1_zero   = r_zero;

    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_control = r_op;

    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_share_ctrl
//  Purpose  : Self-checking bench for alu_share_ctrl. Two instances: one in
//             round-robin mode, one in fixed-priority mode, each with its own
//             combinational ALU model. Expected responses are queued when an
//             operation is accepted and compared when the response appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // round-robin instance
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_control;
    logic        alu_zero, busy;

    // fixed-priority instance
    logic        f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
    logic [31:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
    logic [3:0]  f_req0_op, f_req1_op;
    logic        f_rsp0_valid, f_rsp0_ready, f_rsp1_valid, f_rsp1_ready;
    logic [31:0] f_rsp0_result, f_rsp1_result;
    logic        f_rsp0_zero, f_rsp1_zero;
    logic [31:0] f_alu_a, f_alu_b, f_alu_result;
    logic [3:0]  f_alu_control;
    logic        f_alu_zero, f_busy;

    typedef struct {
        int          port;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference ALU: {zero, result}
    function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: r = a ^ b;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    always_comb {alu_zero, alu_result}     = alu_fn(alu_control, alu_a, alu_b);
    always_comb {f_alu_zero, f_alu_result} = alu_fn(f_alu_control, f_alu_a, f_alu_b);

    alu_share_ctrl #(.PRIORITY_MODE(0)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    alu_share_ctrl #(.PRIORITY_MODE(1)) u_dut_fixed (
        .clk(clk), .rst(rst),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(f_req0_a), .req0_b(f_req0_b), .req0_op(f_req0_op),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(f_req1_a), .req1_b(f_req1_b), .req1_op(f_req1_op),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(f_rsp0_ready), .rsp0_result(f_rsp0_result), .rsp0_zero(f_rsp0_zero),
        .rsp1_valid(f_rsp1_valid), .rsp1_ready(f_rsp1_ready), .rsp1_result(f_rsp1_result), .rsp1_zero(f_rsp1_zero),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_control(f_alu_control),
        .alu_result(f_alu_result), .alu_zero(f_alu_zero), .busy(f_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        if (sbq.size() == 0) begin
            e.port = -1; e.res = 32'hDEAD_BEEF; e.zero = 1'b0;
        end else begin
            e = sbq.pop_front();
        end
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        f_req0_valid = 0; f_req1_valid = 0; f_rsp0_ready = 0; f_rsp1_ready = 0;
        f_req0_a = 0; f_req0_b = 0; f_req0_op = 0; f_req1_a = 0; f_req1_b = 0; f_req1_op = 0;
        step(); step();
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", {req0_ready, req1_ready}); end
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", {rsp0_valid, rsp1_valid}); end
        checks++; if ({rsp0_result, rsp0_zero, rsp1_result, rsp1_zero} !== 66'd0) begin failures++; $display("FAIL reset_rsp_data got=%h/%b %h/%b exp=0", rsp0_result, rsp0_zero, rsp1_result, rsp1_zero); end
        checks++; if ({alu_a, alu_b, alu_control} !== 68'd0) begin failures++; $display("FAIL reset_alu got=%h %h %h exp=0", alu_a, alu_b, alu_control); end
        checks++; if (busy !== 1'b0 || f_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b/%b exp=0/0", busy, f_busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_op();
        exp_t e;
        req0_a = 32'h5; req0_b = 32'h3; req0_op = 4'b0010; req0_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL single_ready got=%b%b exp=10", req0_ready, req1_ready); end
        sbq.push_back('{port: 0, res: 32'h8, zero: 1'b0});
        step();
        req0_valid = 1'b0;
        checks++; if (busy !== 1'b1 || rsp0_valid !== 1'b0) begin failures++; $display("FAIL single_exec got busy=%b rsp0_valid=%b exp busy=1 rsp0_valid=0", busy, rsp0_valid); end
        checks++; if ({alu_a, alu_b, alu_control} !== {32'h5, 32'h3, 4'b0010}) begin failures++; $display("FAIL single_alu_in got=%h %h %h exp=5 3 2", alu_a, alu_b, alu_control); end
        step();
        checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_valid got=%b%b exp=10", rsp0_valid, rsp1_valid); end
        e = pop_exp();
        checks++; if (e.port != 0 || rsp0_result !== e.res || rsp0_zero !== e.zero) begin failures++; $display("FAIL single_rsp_data got=%h z=%b exp=%h z=%b", rsp0_result, rsp0_zero, e.res, e.zero); end
        rsp0_ready = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin failures++; $display("FAIL single_idle got busy=%b rsp0_valid=%b exp=0 0", busy, rsp0_valid); end
        rsp0_ready = 1'b0;
    endtask

    task automatic test_slt_sub();
        logic [31:0] ta [3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h5};
        logic [31:0] tb [3] = '{32'h0000_0001, 32'h1234_5678, 32'h5};
        logic [3:0]  top [3] = '{4'b0111, 4'b0110, 4'b1111};
        logic [31:0] tr [3] = '{32'h1, 32'h0, 32'h0};
        logic        tz [3] = '{1'b0, 1'b1, 1'b1};
        exp_t e;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req1_a = ta[i]; req1_b = tb[i]; req1_op = top[i]; req1_valid = 1'b1;
            #1;
            checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin failures++; $display("FAIL op%0d_ready got=%b%b exp=01", i, req0_ready, req1_ready); end
            sbq.push_back('{port: 1, res: tr[i], zero: tz[i]});
            step();
            req1_valid = 1'b0;
            checks++; if (alu_control !== top[i]) begin failures++; $display("FAIL op%0d_ctrl got=%b exp=%b", i, alu_control, top[i]); end
            step();
            e = pop_exp();
            checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || e.port != 1 || rsp1_result !== e.res || rsp1_zero !== e.zero) begin
                failures++; $display("FAIL op%0d_rsp got v=%b%b %h z=%b exp v=01 %h z=%b", i, rsp0_valid, rsp1_valid, rsp1_result, rsp1_zero, e.res, e.zero);
            end
            step();
        end
        rsp1_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int acc = 0, rsps = 0, last_acc = -1, upd, gport;
        int grants[$];
        exp_t e;
        logic [32:0] zr;
        logic [31:0] gres;
        logic        gzero;
        req0_op = 4'b0010; req0_a = 32'd1;    req0_b = 32'd100;
        req1_op = 4'b0110; req1_a = 32'd1000; req1_b = 32'd1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && (acc < 4 || rsps < 4); cyc++) begin
            if (acc >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            #1;
            upd = -1;
            checks++; if (req0_ready && req1_ready) begin failures++; $display("FAIL rr_both_ready cyc=%0d got=11 exp=not 11", cyc); end
            if (rsp0_valid || rsp1_valid) begin
                e = pop_exp();
                gport = rsp1_valid ? 1 : 0;
                gres  = rsp1_valid ? rsp1_result : rsp0_result;
                gzero = rsp1_valid ? rsp1_zero : rsp0_zero;
                checks++; if ((rsp0_valid && rsp1_valid) || e.port != gport || gres !== e.res || gzero !== e.zero) begin
                    failures++; $display("FAIL rr_rsp%0d got port=%0d %h z=%b exp port=%0d %h z=%b", rsps, gport, gres, gzero, e.port, e.res, e.zero);
                end
                rsps++;
            end
            if (acc < 4 && (req0_ready || req1_ready)) begin
                upd = req1_ready ? 1 : 0;
                grants.push_back(upd);
                if (last_acc >= 0) begin
                    checks++; if (cyc - last_acc != 3) begin failures++; $display("FAIL rr_interval got=%0d exp=3", cyc - last_acc); end
                end
                last_acc = cyc;
                zr = upd ? alu_fn(req1_op, req1_a, req1_b) : alu_fn(req0_op, req0_a, req0_b);
                sbq.push_back('{port: upd, res: zr[31:0], zero: zr[32]});
                acc++;
            end
            step();
            if (upd == 0) req0_a = req0_a + 32'd7;
            else if (upd == 1) req1_b = req1_b + 32'd3;
        end
        checks++; if (acc != 4 || rsps != 4) begin failures++; $display("FAIL rr_counts got acc=%0d rsp=%0d exp=4 4", acc, rsps); end
        checks++; if (grants.size() != 4 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
            failures++; $display("FAIL rr_order got=%p exp=0,1,0,1", grants);
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_fixed_priority();
        int acc = 0, rsps = 0;
        exp_t e;
        f_req0_op = 4'b0010; f_req0_a = 32'd10;    f_req0_b = 32'd20;
        f_req1_op = 4'b0001; f_req1_a = 32'h0F0;   f_req1_b = 32'h00F;
        f_rsp0_ready = 1'b1; f_rsp1_ready = 1'b1; f_req0_valid = 1'b1; f_req1_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && (acc < 4 || rsps < 4); cyc++) begin
            if (acc >= 4) begin f_req0_valid = 1'b0; f_req1_valid = 1'b0; end
            #1;
            if (f_req0_valid) begin
                checks++; if (f_req1_ready !== 1'b0) begin failures++; $display("FAIL fp_req1_ready cyc=%0d got=%b exp=0", cyc, f_req1_ready); end
            end
            if (f_rsp0_valid || f_rsp1_valid) begin
                e = pop_exp();
                checks++; if (f_rsp1_valid || e.port != 0 || f_rsp0_result !== e.res || f_rsp0_zero !== e.zero) begin
                    failures++; $display("FAIL fp_rsp%0d got v=%b%b %h exp v=10 %h", rsps, f_rsp0_valid, f_rsp1_valid, f_rsp0_result, e.res);
                end
                rsps++;
            end
            if (acc < 4 && f_req0_ready) begin
                sbq.push_back('{port: 0, res: 32'd30, zero: 1'b0});
                acc++;
            end
            step();
        end
        checks++; if (acc != 4 || rsps != 4) begin failures++; $display("FAIL fp_counts got acc=%0d rsp=%0d exp=4 4", acc, rsps); end
        f_req1_valid = 1'b1;
        #1;
        checks++; if (f_req1_ready !== 1'b1 || f_req0_ready !== 1'b0) begin failures++; $display("FAIL fp_req1_alone got=%b%b exp=01", f_req0_ready, f_req1_ready); end
        sbq.push_back('{port: 1, res: 32'hFF, zero: 1'b0});
        step();
        f_req1_valid = 1'b0;
        step();
        e = pop_exp();
        checks++; if (f_rsp1_valid !== 1'b1 || f_rsp0_valid !== 1'b0 || e.port != 1 || f_rsp1_result !== e.res) begin
            failures++; $display("FAIL fp_rsp1 got v=%b%b %h exp v=01 %h", f_rsp0_valid, f_rsp1_valid, f_rsp1_result, e.res);
        end
        step();
        f_rsp0_ready = 1'b0; f_rsp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e;
        req0_a = 32'hF0F0_F0F0; req0_b = 32'h0FF0_0FF0; req0_op = 4'b1100; req0_valid = 1'b1;
        rsp0_ready = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL bp_accept got=%b exp=1", req0_ready); end
        sbq.push_back('{port: 0, res: 32'hFF00_FF00, zero: 1'b0});
        step();
        req0_valid = 1'b0;
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if ({rsp0_valid, busy, req0_ready, req1_ready, rsp0_result, rsp0_zero} !== {4'b1100, 32'hFF00_FF00, 1'b0}) begin
                failures++; $display("FAIL bp_hold%0d got v=%b busy=%b rdy=%b%b %h z=%b exp v=1 busy=1 rdy=00 ff00ff00 z=0", i, rsp0_valid, busy, req0_ready, req1_ready, rsp0_result, rsp0_zero);
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1;
        e = pop_exp();
        checks++; if (e.port != 0 || rsp0_result !== e.res || rsp0_zero !== e.zero) begin failures++; $display("FAIL bp_rsp got=%h exp=%h", rsp0_result, e.res); end
        step();
        checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin failures++; $display("FAIL bp_release got busy=%b v=%b exp=0 0", busy, rsp0_valid); end
        rsp0_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        req0_a = 32'd7; req0_b = 32'd9; req0_op = 4'b0010; req0_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_accept got=%b exp=1", req0_ready); end
        step();
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin failures++; $display("FAIL rst_mid_flags got=%b exp=000", {rsp0_valid, rsp1_valid, busy}); end
        checks++; if ({alu_a, alu_b, alu_control} !== 68'd0) begin failures++; $display("FAIL rst_mid_alu got=%h %h %h exp=0", alu_a, alu_b, alu_control); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin failures++; $display("FAIL rst_mid_quiet%0d got=%b exp=000", i, {rsp0_valid, rsp1_valid, busy}); end
        end
        // Both valid: the reset value of last_grant must give req0 the win.
        req0_a = 32'd2; req0_b = 32'd2; req0_op = 4'b0010; req0_valid = 1'b1;
        req1_a = 32'd9; req1_b = 32'd4; req1_op = 4'b0110; req1_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_grant got=%b%b exp=10", req0_ready, req1_ready); end
        sbq.push_back('{port: 0, res: 32'd4, zero: 1'b0});
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        e = pop_exp();
        checks++; if (rsp0_valid !== 1'b1 || e.port != 0 || rsp0_result !== e.res || rsp0_zero !== e.zero) begin
            failures++; $display("FAIL rst_mid_next got v=%b %h exp v=1 %h", rsp0_valid, rsp0_result, e.res);
        end
        step();
        checks++; if (sbq.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", sbq.size()); end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_slt_sub();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
